// File: rtl/generic_fifo.sv
// generic_fifo
//   Synchronous FIFO of 2^AW words, each DW bits wide. Read data is registered.
//   A valid/ready handshake qualifies every push and every pop.
//
// Ports
//   clk        rising-edge clock for every register
//   rst        asynchronous reset, active low
//   data_in    write data
//   wr_en      write request; valid_in1 qualifies it
//   rd_en      read request; ready_in2 qualifies it
//   valid_in1  upstream valid
//   ready_in2  downstream ready
//   data_out   registered read data; holds its value when no read occurs
//   full       FIFO holds 2^AW entries
//   empty      FIFO holds 0 entries
//   ready_out1 !full, sent to the upstream stage
//   valid_out2 !empty, sent to the downstream stage
//   level      present only when GENERIC_FIFO_LEVEL_EN is defined; gives the
//              occupancy, wp - rp
//
// Optional build macro: GENERIC_FIFO_LEVEL_EN adds the level output.

module generic_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_in,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic          valid_in1,
  input  logic          ready_in2,
  output logic [DW-1:0] data_out,
  output logic          full,
  output logic          empty,
  output logic          ready_out1,
  output logic          valid_out2
`ifdef GENERIC_FIFO_LEVEL_EN
  ,
  output logic [AW:0]   level
`endif
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wp;
  logic [AW:0]   rp;
  logic          we;
  logic          re;

  // Each pointer carries one extra wrap bit. Equal pointers mean empty.
  // Pointers whose low bits match but whose wrap bits differ mean full.
  assign empty      = (wp == rp);
  assign full       = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign ready_out1 = !full;
  assign valid_out2 = !empty;

  assign we = wr_en & valid_in1 & !full;
  assign re = rd_en & ready_in2 & !empty;

  // The storage has no reset. Only entries that have been written are ever read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wp[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp       <= '0;
      rp       <= '0;
      data_out <= '0;
    end else begin
      if (we) begin
        wp <= wp + 1'b1;
      end
      if (re) begin
        data_out <= mem[rp[AW-1:0]];
        rp       <= rp + 1'b1;
      end
    end
  end

`ifdef GENERIC_FIFO_LEVEL_EN
  // The subtraction wraps modulo 2^(AW+1), so the result stays in 0..2^AW.
  assign level = wp - rp;
`endif

endmodule

// File: tb/tb_generic_fifo.sv
module tb_generic_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       wr_en;
  logic       rd_en;
  logic       valid_in1;
  logic       ready_in2;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       ready_out1;
  logic       valid_out2;
`ifdef GENERIC_FIFO_LEVEL_EN
  logic [4:0] level;
`endif

  int total;
  int bad;

  generic_fifo #(.DW(8), .AW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .valid_in1  (valid_in1),
    .ready_in2  (ready_in2),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty),
    .ready_out1 (ready_out1),
    .valid_out2 (valid_out2)
`ifdef GENERIC_FIFO_LEVEL_EN
    ,
    .level      (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (10) tick();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_out); end
    total++; if (ready_out1 !== 1'b1) begin bad++; $display("FAIL reset_ready_out1 got=%b exp=1", ready_out1); end
    total++; if (valid_out2 !== 1'b0) begin bad++; $display("FAIL reset_valid_out2 got=%b exp=0", valid_out2); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ordering();
    logic [7:0] vals [8];
    int         gaps [8];
    vals = '{8'h3C, 8'hA5, 8'h01, 8'hFF, 8'h7E, 8'h00, 8'h96, 8'h5A};
    gaps = '{0, 2, 4, 1, 3, 0, 2, 1};
    valid_in1 = 1'b1;
    ready_in2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      data_in = vals[i];
      tick();
      wr_en = 1'b0;
      if (i == 0) begin
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL order_empty_fall got=%b exp=0", empty); end
      end
      repeat (gaps[i]) tick();
    end
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      tick();
      total++; if (data_out !== vals[i]) begin bad++; $display("FAIL order_read%0d got=%h exp=%h", i, data_out, vals[i]); end
    end
    rd_en = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL order_empty_end got=%b exp=1", empty); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      data_in = 8'(i);
      tick();
      if (i == 14) begin
        total++; if (full !== 1'b0) begin bad++; $display("FAIL fill_full_early got=%b exp=0", full); end
      end
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full); end
    total++; if (ready_out1 !== 1'b0) begin bad++; $display("FAIL fill_ready_out1 got=%b exp=0", ready_out1); end
    data_in = 8'hAA;
    tick();
    wr_en = 1'b0;
    total++; if (full !== 1'b1) begin bad++; $display("FAIL overflow_full got=%b exp=1", full); end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      tick();
      total++; if (data_out !== 8'(i)) begin bad++; $display("FAIL fill_read%0d got=%h exp=%h", i, data_out, 8'(i)); end
      if (i == 0) begin
        total++; if (full !== 1'b0) begin bad++; $display("FAIL fill_full_fall got=%b exp=0", full); end
      end
    end
    rd_en = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fill_empty_end got=%b exp=1", empty); end
  endtask

  task automatic test_underflow();
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (data_out !== 8'h0F) begin bad++; $display("FAIL underflow_data%0d got=%h exp=0f", i, data_out); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL underflow_empty%0d got=%b exp=1", i, empty); end
    end
    // A read and a write arrive together while the FIFO is empty, so only the write takes effect.
    wr_en   = 1'b1;
    data_in = 8'h33;
    tick();
    wr_en = 1'b0;
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL empty_rw_empty got=%b exp=0", empty); end
    total++; if (data_out !== 8'h0F) begin bad++; $display("FAIL empty_rw_data got=%h exp=0f", data_out); end
    tick();
    rd_en = 1'b0;
    total++; if (data_out !== 8'h33) begin bad++; $display("FAIL next_edge_read got=%h exp=33", data_out); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL next_edge_empty got=%b exp=1", empty); end
  endtask

  task automatic test_qualifiers();
    wr_en     = 1'b1;
    valid_in1 = 1'b0;
    data_in   = 8'hEE;
    tick();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL qual_no_valid got=%b exp=1", empty); end
    valid_in1 = 1'b1;
    data_in   = 8'h5C;
    tick();
    wr_en     = 1'b0;
    rd_en     = 1'b1;
    ready_in2 = 1'b0;
    repeat (2) tick();
    total++; if (data_out !== 8'h33) begin bad++; $display("FAIL qual_no_ready_data got=%h exp=33", data_out); end
    total++; if (valid_out2 !== 1'b1) begin bad++; $display("FAIL qual_no_ready_valid got=%b exp=1", valid_out2); end
    ready_in2 = 1'b1;
    tick();
    rd_en = 1'b0;
    total++; if (data_out !== 8'h5C) begin bad++; $display("FAIL qual_read got=%h exp=5c", data_out); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL qual_empty got=%b exp=1", empty); end
  endtask

  task automatic test_simul_wrap();
    logic [7:0] q [$];
    logic [7:0] exp;
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      data_in = 8'hA0 + 8'(i);
      q.push_back(data_in);
      tick();
    end
    rd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      data_in = 8'hB0 + 8'(i);
      tick();
      exp = q.pop_front();
      q.push_back(data_in);
      total++; if (data_out !== exp) begin bad++; $display("FAIL wrap_data%0d got=%h exp=%h", i, data_out, exp); end
      total++; if (valid_out2 !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL wrap_flags%0d got=%b%b exp=10", i, valid_out2, full); end
`ifdef GENERIC_FIFO_LEVEL_EN
      total++; if (level !== 5'd3) begin bad++; $display("FAIL wrap_level%0d got=%0d exp=3", i, level); end
`endif
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = q.pop_front();
      total++; if (data_out !== exp) begin bad++; $display("FAIL wrap_drain%0d got=%h exp=%h", i, data_out, exp); end
    end
    rd_en = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  task automatic test_reset_mid();
    wr_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      data_in = 8'hC0 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++; if (data_out !== 8'hC0) begin bad++; $display("FAIL mid_pre_read got=%h exp=c0", data_out); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL mid_async_empty got=%b exp=1", empty); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL mid_async_data got=%h exp=00", data_out); end
    tick();
    rst = 1'b1;
    tick();
    wr_en   = 1'b1;
    data_in = 8'h42;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++; if (data_out !== 8'h42) begin bad++; $display("FAIL mid_post_read got=%h exp=42", data_out); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL mid_post_empty got=%b exp=1", empty); end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    data_in   = 8'h00;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    valid_in1 = 1'b0;
    ready_in2 = 1'b0;
    test_reset();
    test_ordering();
    test_fill_overflow();
    test_underflow();
    test_qualifiers();
    test_simul_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
